// File: rtl/dsdmnist_argmax.sv
// Argmax over NCLASS signed class scores: capture on i_START, scan one score per cycle,
// then present the winning index and score with a one-cycle o_VALID pulse.
module dsdmnist_argmax #(
   parameter int NCLASS = 10,
   parameter int DW     = 32
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_START,
   input  logic signed [DW-1:0] i_DIN [0:NCLASS-1],
   output logic                 o_BUSY,
   output logic                 o_VALID,
   output logic [3:0]           o_CLASS,
   output logic signed [DW-1:0] o_MAX
);

   localparam int IW = $clog2(NCLASS);
   localparam int CW = $clog2(NCLASS + 1);
   localparam logic [CW-1:0] LAST = CW'(NCLASS);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic signed [DW-1:0]  bank [0:NCLASS-1];
   logic signed [DW-1:0]  best;
   logic [3:0]            bestidx;

   assign idx = cnt[IW-1:0];

   always_ff @(posedge i_CLK) begin
      if (i_RST) state <= IDLE;
      else       state <= state_nxt;
   end

   // The cnt == NCLASS cycle performs no compare; it only lets the final
   // comparison settle in best before the result is published.
   always_comb begin
      state_nxt = state;
      o_BUSY    = 1'b0;
      o_VALID   = 1'b0;
      case (state)
         IDLE: if (i_START) state_nxt = SCAN;
         SCAN: begin
            o_BUSY = 1'b1;
            if (i_START)          state_nxt = SCAN;
            else if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            o_VALID   = 1'b1;
            state_nxt = i_START ? SCAN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_START) bank <= i_DIN;
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         cnt     <= '0;
         best    <= '0;
         bestidx <= '0;
         o_CLASS <= '0;
         o_MAX   <= '0;
      end else if (i_START) begin
         best    <= i_DIN[0];
         bestidx <= '0;
         cnt     <= CW'(1);
      end else if (state == SCAN) begin
         if (cnt == LAST) begin
            o_CLASS <= bestidx;
            o_MAX   <= best;
         end else begin
            if (bank[idx] > best) begin
               best    <= bank[idx];
               bestidx <= 4'(idx);
            end
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dsdmnist_argmax.sv
// Randomized self-checking bench for dsdmnist_argmax against a max-then-first-index model.
module tb_dsdmnist_argmax;

   logic               i_CLK = 1'b0;
   logic               i_RST;
   logic               i_START;
   logic signed [31:0] i_DIN [0:9];
   logic               o_BUSY;
   logic               o_VALID;
   logic [3:0]         o_CLASS;
   logic signed [31:0] o_MAX;

   logic signed [31:0] pat [0:9];
   int unsigned        exp_cls;
   logic signed [31:0] exp_max;
   int                 vecs = 0;
   int                 errs = 0;

   dsdmnist_argmax #(.NCLASS(10), .DW(32)) dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_START(i_START), .i_DIN(i_DIN),
      .o_BUSY(o_BUSY), .o_VALID(o_VALID), .o_CLASS(o_CLASS), .o_MAX(o_MAX)
   );

   always #5 i_CLK = ~i_CLK;

   // Reference: find the maximum value, then the lowest index holding it.
   task automatic model();
      logic signed [31:0] m;
      m = pat[0];
      for (int i = 1; i < 10; i++) if (pat[i] > m) m = pat[i];
      for (int i = 9; i >= 0; i--) if (pat[i] == m) exp_cls = i;
      exp_max = m;
   endtask

   task automatic scramble();
      for (int i = 0; i < 10; i++) i_DIN[i] = $urandom;
   endtask

   // Called on a negedge: drive pat with i_START for one cycle.
   task automatic apply_start();
      i_DIN = pat;
      i_START = 1'b1;
      model();
      @(negedge i_CLK);
      i_START = 1'b0;
   endtask

   // Called at the first negedge after the start edge; follows the scan to the result.
   task automatic check_scan(input string name);
      for (int k = 1; k <= 10; k++) begin
         vecs++;
         if (o_BUSY !== 1'b1 || o_VALID !== 1'b0) begin
            errs++;
            $display("FAIL %s scan_k%0d: busy=%b valid=%b expected busy=1 valid=0", name, k, o_BUSY, o_VALID);
         end
         scramble();
         @(negedge i_CLK);
      end
      vecs++;
      if (o_VALID !== 1'b1 || o_BUSY !== 1'b0 || o_CLASS !== 4'(exp_cls) || o_MAX !== exp_max) begin
         errs++;
         $display("FAIL %s result: valid=%b busy=%b class=%0d max=%0d expected valid=1 busy=0 class=%0d max=%0d",
                  name, o_VALID, o_BUSY, o_CLASS, o_MAX, exp_cls, exp_max);
      end
      @(negedge i_CLK);
      vecs++;
      if (o_VALID !== 1'b0 || o_BUSY !== 1'b0 || o_CLASS !== 4'(exp_cls) || o_MAX !== exp_max) begin
         errs++;
         $display("FAIL %s hold: valid=%b busy=%b class=%0d max=%0d expected valid=0 busy=0 class=%0d max=%0d",
                  name, o_VALID, o_BUSY, o_CLASS, o_MAX, exp_cls, exp_max);
      end
   endtask

   task automatic test_reset();
      i_RST = 1'b1; i_START = 1'b0; scramble();
      repeat (3) @(negedge i_CLK);
      vecs++;
      if (o_BUSY !== 1'b0 || o_VALID !== 1'b0 || o_CLASS !== 4'd0 || o_MAX !== 32'sd0) begin
         errs++;
         $display("FAIL reset_state: busy=%b valid=%b class=%0d max=%0d expected all 0", o_BUSY, o_VALID, o_CLASS, o_MAX);
      end
      i_START = 1'b1;
      @(negedge i_CLK);
      i_START = 1'b0; i_RST = 1'b0;
      vecs++;
      if (o_BUSY !== 1'b0) begin
         errs++;
         $display("FAIL reset_priority: busy=%b expected 0", o_BUSY);
      end
      @(negedge i_CLK);
   endtask

   task automatic test_directed();
      pat = '{32'sd5, -32'sd3, 32'sd100, 32'sd7, 32'sd100, 32'sd0, -32'sd1, 32'sd2, 32'sd99, -32'sd100};
      apply_start(); check_scan("tie_low_index");
      for (int i = 0; i < 10; i++) pat[i] = 32'sh80000000;
      apply_start(); check_scan("all_most_negative");
      for (int i = 0; i < 9; i++) pat[i] = -32'sd1;
      pat[9] = 32'sd0;
      apply_start(); check_scan("last_index_wins");
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 10; i++) begin
            case (n % 3)
               0: pat[i] = $urandom;
               1: pat[i] = $signed($urandom_range(8)) - 32'sd4;
               default: pat[i] = ($urandom_range(3) == 0) ? 32'sh80000000 : 32'sh80000000 + $signed($urandom_range(2));
            endcase
         end
         apply_start(); check_scan("random");
         for (int g = $urandom_range(3); g > 0; g--) begin
            scramble();
            @(negedge i_CLK);
            vecs++;
            if (o_VALID !== 1'b0 || o_BUSY !== 1'b0 || o_CLASS !== 4'(exp_cls) || o_MAX !== exp_max) begin
               errs++;
               $display("FAIL idle_hold: valid=%b busy=%b class=%0d max=%0d expected 0/0/%0d/%0d",
                        o_VALID, o_BUSY, o_CLASS, o_MAX, exp_cls, exp_max);
            end
         end
      end
   endtask

   task automatic test_abort();
      for (int i = 0; i < 10; i++) pat[i] = $signed($urandom_range(50));
      pat[1] = 32'sd1000;
      apply_start();
      for (int k = 1; k < 4; k++) begin
         scramble();
         @(negedge i_CLK);
      end
      for (int i = 0; i < 10; i++) pat[i] = $signed($urandom_range(50)) - 32'sd25;
      pat[6] = 32'sd77;
      apply_start(); check_scan("restart_in_scan");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) pat[i] = $urandom;
      apply_start();
      repeat (4) @(negedge i_CLK);
      i_RST = 1'b1;
      @(negedge i_CLK);
      i_RST = 1'b0;
      for (int k = 0; k < 12; k++) begin
         vecs++;
         if (o_VALID !== 1'b0 || o_BUSY !== 1'b0 || o_CLASS !== 4'd0 || o_MAX !== 32'sd0) begin
            errs++;
            $display("FAIL reset_mid_scan: valid=%b busy=%b class=%0d max=%0d expected all 0", o_VALID, o_BUSY, o_CLASS, o_MAX);
         end
         scramble();
         @(negedge i_CLK);
      end
      for (int i = 0; i < 10; i++) pat[i] = $urandom;
      apply_start(); check_scan("after_reset");
   endtask

   task automatic test_back_to_back();
      int unsigned        a_cls;
      logic signed [31:0] a_max;
      for (int i = 0; i < 10; i++) pat[i] = $urandom;
      apply_start();
      a_cls = exp_cls; a_max = exp_max;
      repeat (10) begin scramble(); @(negedge i_CLK); end
      vecs++;
      if (o_VALID !== 1'b1 || o_CLASS !== 4'(a_cls) || o_MAX !== a_max) begin
         errs++;
         $display("FAIL b2b_first: valid=%b class=%0d max=%0d expected 1/%0d/%0d", o_VALID, o_CLASS, o_MAX, a_cls, a_max);
      end
      for (int i = 0; i < 10; i++) pat[i] = $urandom;
      apply_start();
      vecs++;
      if (o_CLASS !== 4'(a_cls) || o_MAX !== a_max) begin
         errs++;
         $display("FAIL b2b_hold_old: class=%0d max=%0d expected %0d/%0d", o_CLASS, o_MAX, a_cls, a_max);
      end
      check_scan("b2b_second");
   endtask

   initial begin
      i_RST = 1'b1; i_START = 1'b0;
      @(negedge i_CLK);
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
